// File: rtl/debounce_pulse.sv
// Push-button debouncer: two-flop synchronizer, four-state qualify FSM,
// one-cycle press strobe, debounced level and wrapping press counter.
module debounce_pulse #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             iBtn,
  output logic             oPulse,
  output logic             oLevel,
  output logic [CNT_W-1:0] oCount
);

  localparam int DW = $clog2(DB_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PCHK = 2'd1,
    HELD = 2'd2,
    RCHK = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    db_cnt_q, db_cnt_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= IDLE;
      db_cnt_q <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      pulse_q  <= 1'b0;
      level_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      pulse_q  <= pulse_d;
      level_q  <= level_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    s1_d     = iBtn;
    s2_d     = s1_q;
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    pulse_d  = 1'b0;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d  = PCHK;
          db_cnt_d = '0;
        end
      end
      PCHK: begin
        if (!s2_q) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          // press accepted: strobe and count land on the same edge
          state_d = HELD;
          pulse_d = 1'b1;
          count_d = count_q + CNT_W'(1);
        end else begin
          db_cnt_d = db_cnt_q + DW'(1);
        end
      end
      HELD: begin
        if (!s2_q) begin
          state_d  = RCHK;
          db_cnt_d = '0;
        end
      end
      RCHK: begin
        if (s2_q) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          db_cnt_d = db_cnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // registered from next state so the level tracks the FSM with no extra lag
    level_d = (state_d == HELD) || (state_d == RCHK);
  end

  assign oPulse = pulse_q;
  assign oLevel = level_q;
  assign oCount = count_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed bench for debounce_pulse: latency, bounce rejection, glitches,
// asynchronous reset abort and counter wrap.
module tb_debounce_pulse;

  logic       clk = 1'b0;
  logic       nRst;
  logic       iBtn;
  logic       pulse, lvl;
  logic [7:0] cnt;
  logic       pulse1, lvl1;
  logic [7:0] cnt1;

  debounce_pulse #(.DB_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .nRst(nRst), .iBtn(iBtn),
    .oPulse(pulse), .oLevel(lvl), .oCount(cnt)
  );

  debounce_pulse #(.DB_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .nRst(nRst), .iBtn(iBtn),
    .oPulse(pulse1), .oLevel(lvl1), .oCount(cnt1)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   tick_n, pulses, first_pulse, first_rise, first_fall;
  logic prev_lvl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mark();
    tick_n      = 0;
    pulses      = 0;
    first_pulse = -1;
    first_rise  = -1;
    first_fall  = -1;
    prev_lvl    = lvl;
  endtask

  // tick k samples just after edge k-1 when inputs were set before edge 0
  task automatic tick();
    @(posedge clk);
    #1;
    tick_n++;
    if (pulse) begin
      pulses++;
      if (first_pulse < 0) first_pulse = tick_n;
    end
    if (lvl && !prev_lvl && first_rise < 0) first_rise = tick_n;
    if (!lvl && prev_lvl && first_fall < 0) first_fall = tick_n;
    prev_lvl = lvl;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic apply_reset(input string tag);
    nRst = 1'b0;
    #2;
    chk({tag, "_pulse"}, 32'(pulse), 0);
    chk({tag, "_level"}, 32'(lvl), 0);
    chk({tag, "_count"}, 32'(cnt), 0);
    @(posedge clk);
    #1;
    nRst = 1'b1;
  endtask

  initial begin
    nRst = 1'b0;
    iBtn = 1'b0;
    #12;
    chk("rst_pulse", 32'(pulse), 0);
    chk("rst_level", 32'(lvl), 0);
    chk("rst_count", 32'(cnt), 0);
    chk("rst_db1_count", 32'(cnt1), 0);
    @(posedge clk);
    #1;
    nRst = 1'b1;

    // clean press held 20 cycles
    mark();
    iBtn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("db1_pulse", 32'(pulse1), 32'(k == 4));
    end
    chk("clean_first_pulse", 32'(first_pulse), 7);
    chk("clean_pulses", 32'(pulses), 1);
    chk("clean_level_rise", 32'(first_rise), 7);
    chk("clean_count", 32'(cnt), 1);
    chk("db1_count", 32'(cnt1), 1);

    // release with a 2-cycle bounce back to 1, then stable 0
    mark();
    iBtn = 1'b0;
    ticks(2);
    iBtn = 1'b1;
    ticks(2);
    iBtn = 1'b0;
    ticks(12);
    chk("rel_level_fall", 32'(first_fall), 11);
    chk("rel_pulses", 32'(pulses), 0);
    chk("rel_count", 32'(cnt), 1);

    // bouncing press 1,0,1,0 then stable 1
    apply_reset("rst2");
    mark();
    iBtn = 1'b1; tick();
    iBtn = 1'b0; tick();
    iBtn = 1'b1; tick();
    iBtn = 1'b0; tick();
    iBtn = 1'b1;
    ticks(21);
    chk("bounce_first_pulse", 32'(first_pulse), 11);
    chk("bounce_pulses", 32'(pulses), 1);
    chk("bounce_count", 32'(cnt), 1);

    // one-cycle glitch low while held
    mark();
    iBtn = 1'b0; tick();
    iBtn = 1'b1;
    ticks(20);
    chk("hglitch_fall", 32'(first_fall), 32'(-1));
    chk("hglitch_pulses", 32'(pulses), 0);
    chk("hglitch_count", 32'(cnt), 1);

    // settle released, then one-cycle glitch high in IDLE
    iBtn = 1'b0;
    ticks(10);
    chk("idle_level", 32'(lvl), 0);
    mark();
    iBtn = 1'b1; tick();
    iBtn = 1'b0;
    ticks(20);
    chk("iglitch_rise", 32'(first_rise), 32'(-1));
    chk("iglitch_pulses", 32'(pulses), 0);
    chk("iglitch_count", 32'(cnt), 1);

    // reset asserted while in PCHK with the button held
    mark();
    iBtn = 1'b1;
    ticks(4);
    chk("pchk_level", 32'(lvl), 0);
    chk("pchk_count", 32'(cnt), 1);
    apply_reset("rst3");
    mark();
    ticks(20);
    chk("requal_first_pulse", 32'(first_pulse), 7);
    chk("requal_pulses", 32'(pulses), 1);
    chk("requal_count", 32'(cnt), 1);

    // 256 clean presses wrap the counter
    iBtn = 1'b0;
    apply_reset("rst4");
    mark();
    for (int i = 0; i < 256; i++) begin
      iBtn = 1'b1;
      ticks(10);
      iBtn = 1'b0;
      ticks(10);
      if (i == 254) chk("wrap_count_255", 32'(cnt), 255);
    end
    chk("wrap_pulses", 32'(pulses), 256);
    chk("wrap_count", 32'(cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_pulse.md
DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

Interface
REQ-001 Parameter DB_CYCLES, default 4, SHALL set the consecutive synchronized-stable cycles required to accept a press or release; legal range 1..255.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the press counter output.
REQ-003 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port nRst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Port iBtn  input  1  SHALL be the raw, asynchronous, bouncing push-button level (1 = pressed).
REQ-006 Port oPulse  output  1  SHALL be a registered one-cycle strobe per accepted press; it drives the toggle input i of the downstream two-state Moore selector.
REQ-007 Port oLevel  output  1  SHALL be the registered debounced button level.
REQ-008 Port oCount  output  CNT_W  SHALL be the registered count of accepted presses.

Function
REQ-009 iBtn SHALL pass through a two-flop synchronizer (s1, s2) before any use; only s2 SHALL feed the FSM.
REQ-010 The FSM SHALL have four states: IDLE (released), PCHK (press candidate), HELD (pressed), RCHK (release candidate).
REQ-011 A debounce counter of width ceil(log2(DB_CYCLES))+1 SHALL be cleared on every entry to PCHK or RCHK.
REQ-012 IDLE: s2=1 -> PCHK; else stay.
REQ-013 PCHK: s2=0 -> IDLE without pulse; s2=1 and counter = DB_CYCLES-1 -> HELD; otherwise counter increments.
REQ-014 HELD: s2=0 -> RCHK; else stay.
REQ-015 RCHK: s2=1 -> HELD without pulse; s2=0 and counter = DB_CYCLES-1 -> IDLE; otherwise counter increments.
REQ-016 oPulse SHALL be 1 for exactly the one cycle following the edge on which PCHK->HELD occurs, 0 at all other times.
REQ-017 oLevel SHALL be 1 exactly when the state is HELD or RCHK.
REQ-018 oCount SHALL increment by 1 on the same edge that sets oPulse, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-019 Latency: iBtn rising before edge 0 and held stable -> oPulse high between edges DB_CYCLES+2 and DB_CYCLES+3; oLevel rises at edge DB_CYCLES+2.
REQ-020 A glitch shorter than DB_CYCLES synchronized cycles in IDLE or HELD SHALL produce no pulse, no count change and no oLevel change.
REQ-021 Holding the button indefinitely SHALL produce exactly one pulse, with no auto-repeat.
REQ-022 A release bounce (RCHK->HELD) SHALL NOT generate a second pulse.
REQ-023 DB_CYCLES=1 SHALL accept a press on the first PCHK cycle with s2=1.

Reset
REQ-024 nRst=0 SHALL immediately force state IDLE, counter 0, s1=s2=0, oPulse=0, oLevel=0, oCount=0, regardless of clk.
REQ-025 Reset asserted mid-debounce or mid-pulse SHALL abort it; after nRst rises, a still-pressed button SHALL be re-qualified from IDLE and pulse once.
REQ-026 nRst deassertion SHALL be treated as synchronous to clk by the integrating design; the block adds no reset synchronizer.

Verification
REQ-027 Reset then clean press held 20 cycles, DB_CYCLES=4 -> one oPulse high between edges 6 and 7, oLevel=1 from edge 6, oCount=1.
REQ-028 Bouncing press 1,0,1,0 at 1-cycle spacing followed by a stable 1 -> exactly one pulse, measured from the last rising transition; oCount=1.
REQ-029 Release with 2-cycle bounce back to 1, then stable 0 for 10 cycles -> no extra pulse; oLevel falls DB_CYCLES+2 cycles after the final release edge.
REQ-030 256 clean presses with CNT_W=8 -> oCount wraps to 0; 256 pulses counted.
REQ-031 nRst pulsed low while in PCHK with button held -> outputs go to 0 asynchronously; after release of reset, one pulse arrives DB_CYCLES+2 edges later and oCount=1.
REQ-032 1-cycle glitch of iBtn while in IDLE -> oPulse, oLevel and oCount unchanged for 20 cycles.
